// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill engine.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_e;

    localparam int unsigned BLK_BYTES     = 16;
    localparam int unsigned WORDS_PER_BLK = 8;
    localparam int unsigned OFF_W         = 3;
    localparam logic [15:0] BLK_MASK      = 16'hFFF0;

endpackage

// File: rtl/cache_fill_counter.sv
// Word counter for a block fill: sync reset and clear, enable, and a done
// flag once LIMIT words have been counted. The counter is one bit wider than
// the word index so the done state is distinguishable from index 0.
module fill_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             done_o
);

    localparam int unsigned CW = IDX_W + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign idx_o  = cnt_q[IDX_W-1:0];
    assign done_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill engine: on a miss, requests every word of the aligned block
// from main memory (one request per cycle), streams returned words into the
// data array in request order, and writes the tag with the last word.
// Optional build macro: CACHE_CRITICAL_WORD_FIRST_EN (wrap-around fill order
// starting at the missed word, plus a crit_ready port).
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned WORDS_PER_BLK = cache_pkg::WORDS_PER_BLK,
    parameter int unsigned OFF_W         = cache_pkg::OFF_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic              write_tag_array,
    output logic [OFF_W-1:0]  word_index,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] fill_base
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    ,
    output logic              crit_ready
`endif
);

    localparam int unsigned BLK_SIZE = WORDS_PER_BLK * (DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK =
        (ADDR_W == 16 && BLK_SIZE == BLK_BYTES) ? ADDR_W'(BLK_MASK)
                                                : ~ADDR_W'(BLK_SIZE - 1);

    fill_state_e       state_q;
    fill_state_e       state_d;
    logic [ADDR_W-1:0] fill_base_q;
    logic [ADDR_W-1:0] fill_base_d;
    logic              start;

    logic [OFF_W-1:0]  issue_idx;
    logic [OFF_W-1:0]  recv_idx;
    logic              issue_done;
    logic              recv_done;
    logic              issue_en;
    logic              recv_en;
    logic              last_word;
    logic [OFF_W-1:0]  issue_word;
    logic [OFF_W-1:0]  recv_word;

    fill_counter #(
        .LIMIT (WORDS_PER_BLK),
        .IDX_W (OFF_W)
    ) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .en_i   (issue_en),
        .idx_o  (issue_idx),
        .done_o (issue_done)
    );

    fill_counter #(
        .LIMIT (WORDS_PER_BLK),
        .IDX_W (OFF_W)
    ) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .en_i   (recv_en),
        .idx_o  (recv_idx),
        .done_o (recv_done)
    );

    assign issue_en  = (state_q == FILL) && !issue_done;
    // recv_done can never be seen in FILL; the guard keeps stray valids harmless.
    assign recv_en   = (state_q == FILL) && memory_data_valid && !recv_done;
    assign last_word = recv_en && (recv_idx == OFF_W'(WORDS_PER_BLK - 1));

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0] miss_word_q;
    logic [OFF_W-1:0] miss_word_d;

    // Latch the missed word index so the fill order starts there and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_word_q <= '0;
        end else begin
            miss_word_q <= miss_word_d;
        end
    end

    assign miss_word_d = start ? miss_address[OFF_W:1] : miss_word_q;
    assign issue_word  = miss_word_q + issue_idx;
    assign recv_word   = miss_word_q + recv_idx;
    assign crit_ready  = recv_en && (recv_idx == '0);
`else
    assign issue_word  = issue_idx;
    assign recv_word   = recv_idx;
`endif

    // State register and latched block base.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_base_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_base_q <= fill_base_d;
        end
    end

    // Next-state: a miss in IDLE starts a fill; the last returned word ends it.
    always_comb begin
        state_d     = state_q;
        fill_base_d = fill_base_q;
        start       = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    start       = 1'b1;
                    state_d     = FILL;
                    fill_base_d = miss_address & ALIGN_MASK;
                end
            end
            FILL: begin
                if (last_word) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy stalls from the miss cycle; requests and writes only in FILL.
    always_comb begin
        fsm_busy         = 1'b0;
        mem_req          = 1'b0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (state_q)
            IDLE: fsm_busy = miss_detected;
            FILL: begin
                fsm_busy         = 1'b1;
                mem_req          = issue_en;
                write_data_array = recv_en;
                write_tag_array  = last_word;
            end
            default: ;
        endcase
        memory_address = fill_base_q + ADDR_W'({issue_word, 1'b0});
        word_index     = recv_word;
        data_out       = memory_data;
        fill_base      = fill_base_q;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: in-order memory model with
// configurable latency/gaps and a request/write scoreboard.
module tb_cache_fill_fsm;

    localparam int LAT = 4;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] base;
        logic [2:0]  idx;
        bit          last;
        bit          first;
    } exp_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic        write_tag_array;
    logic [2:0]  word_index;
    logic [15:0] data_out;
    logic [15:0] fill_base;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
    logic        crit_ready;
`endif

    cache_fill_fsm #(
        .ADDR_W        (16),
        .DATA_W        (16),
        .WORDS_PER_BLK (8),
        .OFF_W         (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_req           (mem_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .word_index        (word_index),
        .data_out          (data_out),
        .fill_base         (fill_base)
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        ,
        .crit_ready        (crit_ready)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    exp_t  exp_req[$];
    exp_t  exp_wr[$];
    resp_t resp[$];
    int    last_due    = -100;
    bit    gap_mode    = 1'b0;
    bit    force_valid = 1'b0;

    int miss_cyc, first_req_cyc, last_req_cyc, first_wr_cyc, tag_cyc;
    int wr_count, tag_count, crit_count;

    logic        obs_busy, obs_req, obs_wr, obs_tag;
    logic [15:0] obs_addr, obs_base, obs_dout, obs_mdata;
    logic [2:0]  obs_idx;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hBEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue the expected request/write sequence for a miss at addr.
    task automatic push_fill(input logic [15:0] addr);
        logic [15:0] base;
        logic [2:0]  m;
        logic [2:0]  w;
        exp_t        e;
        base = addr & 16'hFFF0;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        m = addr[3:1];
`else
        m = 3'd0;
`endif
        for (int k = 0; k < 8; k++) begin
            w       = m + 3'(k);
            e.addr  = base + {12'd0, w, 1'b0};
            e.base  = base;
            e.idx   = w;
            e.last  = (k == 7);
            e.first = (k == 0);
            exp_req.push_back(e);
            exp_wr.push_back(e);
        end
        miss_cyc      = cyc;
        first_req_cyc = -1;
        last_req_cyc  = -1;
        first_wr_cyc  = -1;
        tag_cyc       = -1;
        wr_count      = 0;
        tag_count     = 0;
        crit_count    = 0;
    endtask

    // Observe the current cycle at the falling edge and score it.
    task automatic sample();
        exp_t  e;
        resp_t r;
        int    gap;
        @(negedge clk);
        obs_busy  = fsm_busy;
        obs_req   = mem_req;
        obs_wr    = write_data_array;
        obs_tag   = write_tag_array;
        obs_addr  = memory_address;
        obs_base  = fill_base;
        obs_idx   = word_index;
        obs_dout  = data_out;
        obs_mdata = memory_data;
        if (mem_req) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            last_req_cyc = cyc;
            if (exp_req.size() == 0) begin
                chk("unexp_req", 1, 0);
            end else begin
                e = exp_req.pop_front();
                chk("req_addr", memory_address, e.addr);
                chk("req_base", fill_base, e.base);
            end
            gap    = gap_mode ? int'($urandom_range(3, 0)) : 0;
            r.due  = ((cyc + LAT) > (last_due + 1) ? (cyc + LAT) : (last_due + 1)) + gap;
            r.addr = memory_address;
            last_due = r.due;
            resp.push_back(r);
        end
        if (write_data_array) begin
            wr_count++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                chk("unexp_wr", 1, 0);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_idx", word_index, e.idx);
                chk("wr_data", data_out, mem_fn(e.addr));
                chk("wr_tag", write_tag_array, e.last);
                chk("wr_base", fill_base, e.base);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
                chk("crit", crit_ready, e.first);
`endif
            end
        end else begin
            if (write_tag_array) chk("tag_no_wr", 1, 0);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
            if (crit_ready) chk("crit_no_wr", 1, 0);
`endif
        end
        if (write_tag_array) begin
            tag_count++;
            tag_cyc = cyc;
        end
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        if (crit_ready) crit_count++;
`endif
    endtask

    // Drive the memory response for the new cycle.
    task automatic drive_mem();
        resp_t r;
        memory_data_valid = 1'b0;
        memory_data       = 16'($urandom);
        if (resp.size() > 0 && resp[0].due == cyc) begin
            r = resp.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = mem_fn(r.addr);
        end
        if (force_valid) memory_data_valid = 1'b1;
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (obs_busy && n < 200);
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic check_fill_done(input string tag);
        chk({tag, "_wr_count"}, wr_count, 8);
        chk({tag, "_tag_count"}, tag_count, 1);
        chk({tag, "_req_left"}, exp_req.size(), 0);
        chk({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    initial begin
        int n;
        int phase;
        rst               = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = '0;
        memory_data       = '0;
        memory_data_valid = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", obs_busy, 0);
        chk("rst_req", obs_req, 0);
        chk("rst_wr", obs_wr, 0);
        chk("rst_tag", obs_tag, 0);
        chk("rst_base", obs_base, 16'h0000);
        chk("rst_addr", obs_addr, 16'h0000);
        chk("rst_idx", obs_idx, 0);
        chk("rst_dout", obs_dout, obs_mdata);

        // Directed fill, latency 4, miss at 0x1236.
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        push_fill(16'h1236);
        for (int k = 0; k <= 13; k++) begin
            tick();
            if (k == 0) miss_detected = 1'b0;
            chk("busy_window", obs_busy, (k <= 12));
        end
        chk("first_req_ofs", first_req_cyc - miss_cyc, 1);
        chk("last_req_ofs", last_req_cyc - miss_cyc, 8);
        chk("first_wr_ofs", first_wr_cyc - miss_cyc, 5);
        chk("tag_ofs", tag_cyc - miss_cyc, 12);
        check_fill_done("t1");

        // Irregular response gaps.
        gap_mode      = 1'b1;
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        push_fill(16'h1236);
        tick();
        miss_detected = 1'b0;
        wait_idle();
        check_fill_done("t2");
        gap_mode = 1'b0;
        repeat (3) tick();

        // Miss held through the fill, address changed mid-fill.
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        push_fill(16'h1236);
        n     = 0;
        phase = 0;
        while (n < 200 && phase < 2) begin
            tick();
            n++;
            if (n == 4) miss_address = 16'h4000;
            if (obs_tag) begin
                phase++;
                if (phase == 1) begin
                    chk("t3a_wr_count", wr_count, 8);
                    push_fill(16'h4000);
                end
            end
        end
        miss_detected = 1'b0;
        chk("t3_phases", phase, 2);
        chk("t3_b2b_req_ofs", first_req_cyc - miss_cyc, 1);
        tick();
        chk("t3_busy_after", obs_busy, 0);
        chk("t3_base", obs_base, 16'h4000);
        check_fill_done("t3b");
        repeat (2) tick();

        // Reset in the middle of a fill.
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        push_fill(16'h1236);
        tick();
        miss_detected = 1'b0;
        while (cyc < miss_cyc + 5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_req.delete();
        exp_wr.delete();
        tick();
        chk("t4_busy", obs_busy, 0);
        chk("t4_req", obs_req, 0);
        chk("t4_wr", obs_wr, 0);
        chk("t4_tag", obs_tag, 0);
        chk("t4_base", obs_base, 16'h0000);
        chk("t4_addr", obs_addr, 16'h0000);
        chk("t4_idx", obs_idx, 0);
        repeat (10) begin
            tick();
            chk("t4_late_busy", obs_busy, 0);
        end
        miss_detected = 1'b1;
        miss_address  = 16'hFFFE;
        push_fill(16'hFFFE);
        tick();
        miss_detected = 1'b0;
        wait_idle();
        check_fill_done("t4b");

        // Valid while idle with no miss.
        force_valid = 1'b1;
        tick();
        force_valid = 1'b0;
        chk("t5_wr", obs_wr, 0);
        chk("t5_busy", obs_busy, 0);
        tick();
        chk("t5_busy2", obs_busy, 0);
        chk("t5_base", obs_base, 16'hFFF0);

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
        // Critical word first from word 6.
        miss_detected = 1'b1;
        miss_address  = 16'h123C;
        push_fill(16'h123C);
        tick();
        miss_detected = 1'b0;
        wait_idle();
        check_fill_done("t6");
        chk("t6_crit_count", crit_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
